// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the multi-channel TMDS encoder.
// Symbol constants are written bit9..bit0; bit 0 is transmitted first.
package tmds_pkg;

  localparam logic [1:0] MODE_CTL   = 2'b00;
  localparam logic [1:0] MODE_VID   = 2'b01;
  localparam logic [1:0] MODE_TERC4 = 2'b10;
  localparam logic [1:0] MODE_GUARD = 2'b11;

  localparam logic [9:0] CTL_CODE [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  localparam logic [9:0] GUARD_0 = 10'b1011001100;
  localparam logic [9:0] GUARD_1 = 10'b0100110011;

  localparam logic [9:0] TERC4_TBL [16] = '{
    10'b1010011100, 10'b1001100011,
    10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110,
    10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001,
    10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001,
    10'b0101100011, 10'b1011000011
  };

  function automatic logic [3:0] popcount8(
    input logic [7:0] x
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, x[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// Two-stage single-channel TMDS encoder with its own running disparity.
// TMDS_TERC4_EN adds TERC4 data-island and guard-band symbols.
module tmds_channel
  import tmds_pkg::*;
#(
  parameter int CH_IDX = 0,
  parameter int DISP_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_i,
  input  logic       vld_i,
  input  logic [7:0] din_i,
  input  logic [1:0] ctl_i,
  input  logic [3:0] terc_i,
  output logic [9:0] dout_o
);

  typedef logic signed [DISP_W-1:0] disp_t;
  localparam disp_t TWO = disp_t'(2);

  logic [8:0] qm_d, qm_q;
  logic [1:0] ctl_q;
  logic [9:0] sym_d, dout_q;
  disp_t      cnt_d, cnt_q;

  logic       xnor_sel;
  logic [3:0] n1_din;
  logic [7:0] chain;

  always_comb begin
    n1_din   = popcount8(din_i);
    xnor_sel = (n1_din > 4'd4) ||
               (n1_din == 4'd4 && !din_i[0]);
    chain    = '0;
    chain[0] = din_i[0];
    for (int i = 1; i < 8; i++)
      chain[i] = xnor_sel ? ~(chain[i-1] ^ din_i[i])
                          :  (chain[i-1] ^ din_i[i]);
    qm_d = {~xnor_sel, chain};
  end

  logic [3:0] n1, n0;
  disp_t      n1e, n0e;
  logic       cnt_pos, cnt_neg;
  logic [9:0] vid_sym;
  disp_t      vid_cnt;

  always_comb begin
    n1      = popcount8(qm_q[7:0]);
    n0      = 4'd8 - n1;
    n1e     = disp_t'({{(DISP_W-4){1'b0}}, n1});
    n0e     = disp_t'({{(DISP_W-4){1'b0}}, n0});
    cnt_neg = cnt_q[DISP_W-1];
    cnt_pos = !cnt_neg && (cnt_q != '0);
    if (cnt_q == '0 || n1 == n0) begin
      vid_sym = {~qm_q[8], qm_q[8],
                 qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      vid_cnt = qm_q[8] ? cnt_q + n1e - n0e
                        : cnt_q + n0e - n1e;
    end else if ((cnt_pos && n1 > n0) ||
                 (cnt_neg && n0 > n1)) begin
      vid_sym = {1'b1, qm_q[8], ~qm_q[7:0]};
      vid_cnt = cnt_q + (qm_q[8] ? TWO : '0)
                + n0e - n1e;
    end else begin
      vid_sym = {1'b0, qm_q[8], qm_q[7:0]};
      vid_cnt = cnt_q + n1e - n0e
                - (qm_q[8] ? '0 : TWO);
    end
  end

`ifdef TMDS_TERC4_EN
  localparam logic [9:0] GUARD_SYM =
    (CH_IDX % 3 == 1) ? GUARD_1 : GUARD_0;
  logic [3:0] terc_q;
`else
  logic unused_terc;
  assign unused_terc = ^terc_i;
`endif

  // Every non-video symbol restarts the disparity from zero.
  always_comb begin
    sym_d = CTL_CODE[ctl_q];
    cnt_d = '0;
    unique case (1'b1)
      mode_i == MODE_VID: begin
        sym_d = vid_sym;
        cnt_d = vid_cnt;
      end
`ifdef TMDS_TERC4_EN
      mode_i == MODE_TERC4: sym_d = TERC4_TBL[terc_q];
      mode_i == MODE_GUARD: sym_d = GUARD_SYM;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qm_q   <= '0;
      ctl_q  <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
`ifdef TMDS_TERC4_EN
      terc_q <= '0;
`endif
    end else begin
      qm_q  <= qm_d;
      ctl_q <= ctl_i;
`ifdef TMDS_TERC4_EN
      terc_q <= terc_i;
`endif
      if (vld_i) begin
        dout_q <= sym_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/tmds_encoder_mc.sv
// Registered multi-channel TMDS encoder, 2-cycle latency.
// TMDS_TERC4_EN enables TERC4 islands and guard bands.
module tmds_encoder_mc
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DISP_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 valid_in,
  input  logic [8*NUM_CH-1:0]  din,
  input  logic [2*NUM_CH-1:0]  ctl,
  input  logic [4*NUM_CH-1:0]  terc,
  output logic [10*NUM_CH-1:0] dout,
  output logic                 valid_out
);

  logic [1:0] mode_q;
  logic       vld_q;
  logic       vout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_CTL;
      vld_q  <= 1'b0;
      vout_q <= 1'b0;
    end else begin
      mode_q <= mode;
      vld_q  <= valid_in;
      vout_q <= vld_q;
    end
  end

  assign valid_out = vout_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tmds_channel #(
      .CH_IDX (i),
      .DISP_W (DISP_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .mode_i (mode_q),
      .vld_i  (vld_q),
      .din_i  (din[8*i +: 8]),
      .ctl_i  (ctl[2*i +: 2]),
      .terc_i (terc[4*i +: 4]),
      .dout_o (dout[10*i +: 10])
    );
  end

endmodule

// File: doc/tmds_encoder_mc.md
# tmds_encoder_mc

Registered, multi-channel TMDS symbol encoder. It is the parametrised successor to the team's single-channel combinational encoder. It converts per-channel 8-bit pixel data, 2-bit control, or 4-bit TERC4 auxiliary data into 10-bit DVI/HDMI symbols, and tracks a true running disparity per channel. It sits between the video timing generator and the 10:1 serialisers in the digital_video path.

## Interface
- `NUM_CH`, default 3: number of TMDS data channels.
- `DISP_W`, default 5: width of the signed running-disparity counter; minimum 5.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 2: symbol class.
  - 00: control.
  - 01: video.
  - 10: TERC4 data island.
  - 11: video guard band.
- `valid_in` in 1: input qualifier.
- `din` in 8*NUM_CH: pixel byte; channel i is `din[8*i +: 8]`.
- `ctl` in 2*NUM_CH: {c1,c0}; channel i is `ctl[2*i +: 2]`.
- `terc` in 4*NUM_CH: TERC4 nibble; channel i is `terc[4*i +: 4]`.
- `dout` out 10*NUM_CH: symbols; channel i is `dout[10*i +: 10]`; bit 0 is transmitted first.
- `valid_out` out 1: `dout` holds a new symbol.

## Operation
- Channels are independent and identical. `mode` and `valid_in` are shared by all channels.
- Video mode, stage 1 (per channel), with N1(x) the ones-count and N0(x) the zeros-count:
  - Transition-minimise `din` into `q_m[8:0]`.
  - XNOR chain with `q_m[8]=0` if N1(din)>4, or N1(din)==4 and `din[0]==0`.
  - Otherwise XOR chain with `q_m[8]=1`.
  - `q_m[0]=din[0]`.
- Video mode, stage 2, with N1/N0 taken over `q_m[7:0]`:
  - If `cnt==0` or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - `cnt += q_m[8] ? N1-N0 : N0-N1`.
  - Else if (`cnt>0` and N1>N0) or (`cnt<0` and N0>N1): out = {1, q_m[8], ~q_m[7:0]}.
    - `cnt += 2*q_m[8] + N0-N1`.
  - Else: out = {0, q_m[8], q_m[7:0]}.
    - `cnt += N1-N0 - 2*~q_m[8]`.
- Control mode, codes written bit9..bit0:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- Guard band mode: channel index i mod 3 of 0 or 2 → 1011001100; i mod 3 of 1 → 0100110011.
- Any accepted non-video symbol clears `cnt` to 0 on that channel.
- Arithmetic: `cnt` is a DISP_W-bit signed register and is always even. N-counts are 4-bit unsigned, extended to DISP_W signed before the add. DVI bounds guarantee no overflow at DISP_W ≥ 5.
- `valid_in=0`: the pipeline still shifts. `cnt` is not updated. `valid_out` goes low after the latency. `dout` holds its last valid symbol.
- Mode change takes effect on the cycle it is sampled; there is no draining.

## Timing
- Latency is 2 cycles from `din`/`mode`/`valid_in` to `dout`/`valid_out`. Throughput is one symbol per clock.
- Stage 1 registers the inputs, `mode`, `valid`, and `q_m`. Stage 2 registers `dout` and `cnt`.
- Reset values: `dout=0`, `valid_out=0`, all `cnt=0`, all stage-1 registers 0.
- Reset mid-stream flushes both stages. `valid_out` is 0 on the cycle after `rst` is sampled high and stays 0 until 2 cycles after the first valid input following reset release.
- Simultaneous `rst` and `valid_in`: reset wins and the input is dropped.

## Configuration
- `TMDS_TERC4_EN` defined:
  - Mode 10 encodes each `terc` nibble through the HDMI TERC4 table (0000→1010011100 … 1111→1011000011).
  - Mode 11 emits guard bands.
- Undefined:
  - Modes 10 and 11 behave exactly as control mode, using `ctl`.
  - The `terc` port remains but is ignored; the TERC4 table is not synthesised.

## Structure
- Package `tmds_pkg` holds:
  - the mode encoding constants (MODE_CTL, MODE_VID, MODE_TERC4, MODE_GUARD);
  - the four control codes;
  - the two guard-band codes;
  - the 16-entry TERC4 table;
  - a `popcount8` function.
- Sub-module `tmds_channel` is the 2-stage single-channel encoder with its own `cnt`. It takes the channel index as a parameter for guard-band selection. The top instantiates it NUM_CH times in a generate loop and shares `valid` pipelining.

## Test plan
- Reset: hold `rst` 3 cycles with `valid_in=1` → `dout=0`, `valid_out=0` throughout; after release, first `valid_out=1` exactly 2 cycles after the first valid input.
- Control: mode 00, ch0 `ctl=00`, ch1 `ctl=11` → 2 cycles later ch0=1101010100, ch1=1010101011, `valid_out=1`.
- Video disparity, `cnt=0`, two consecutive `din=8'h00` on ch0:
  - first symbol 0x100, `cnt=-8`;
  - second symbol 0x3FF, `cnt=+2`.
- Video XNOR path: `cnt=0`, `din=8'hFF` → 0x200, `cnt=-8`. Then mode 00 for one cycle, then `din=8'h00` → 0x100, confirming the disparity clear.
- TERC4: with `TMDS_TERC4_EN`, mode 10, `terc=4'h0` on all channels → 1010011100 on every channel. Without the macro, the same stimulus with `ctl=00` → 1101010100.
- Guard: mode 11, NUM_CH=3 → ch0=1011001100, ch1=0100110011, ch2=1011001100. Next video symbol starts from `cnt=0`.
